// File: rtl/icb_2m_to_1s_arb.sv
// Two-master to one-slave ICB arbiter: round-robin registered grant on the command
// channel, in-order response steering from a FIFO of accepted-command owner IDs.
module icb_2m_to_1s_arb #(
  parameter int unsigned outstanding_depth = 4,
  parameter int unsigned simulation_delay  = 1
) (
  input  logic        clk,
  input  logic        rst,

  input  logic [31:0] s0_icb_cmd_addr,
  input  logic        s0_icb_cmd_read,
  input  logic [31:0] s0_icb_cmd_wdata,
  input  logic [3:0]  s0_icb_cmd_wmask,
  input  logic        s0_icb_cmd_valid,
  output logic        s0_icb_cmd_ready,
  output logic [31:0] s0_icb_rsp_rdata,
  output logic        s0_icb_rsp_err,
  output logic        s0_icb_rsp_valid,
  input  logic        s0_icb_rsp_ready,

  input  logic [31:0] s1_icb_cmd_addr,
  input  logic        s1_icb_cmd_read,
  input  logic [31:0] s1_icb_cmd_wdata,
  input  logic [3:0]  s1_icb_cmd_wmask,
  input  logic        s1_icb_cmd_valid,
  output logic        s1_icb_cmd_ready,
  output logic [31:0] s1_icb_rsp_rdata,
  output logic        s1_icb_rsp_err,
  output logic        s1_icb_rsp_valid,
  input  logic        s1_icb_rsp_ready,

  output logic [31:0] m_icb_cmd_addr,
  output logic        m_icb_cmd_read,
  output logic [31:0] m_icb_cmd_wdata,
  output logic [3:0]  m_icb_cmd_wmask,
  output logic        m_icb_cmd_valid,
  input  logic        m_icb_cmd_ready,
  input  logic [31:0] m_icb_rsp_rdata,
  input  logic        m_icb_rsp_err,
  input  logic        m_icb_rsp_valid,
  output logic        m_icb_rsp_ready
);

  localparam int unsigned ptr_w = $clog2(outstanding_depth);
  localparam logic [ptr_w:0] depth_cnt = (ptr_w+1)'(outstanding_depth);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t           state, state_nxt;
  logic             grant_id, grant_nxt;
  logic             last_id, last_nxt;
  logic             push, pop;
  logic             fifo_full, fifo_empty;
  logic             head_id;
  logic             id_mem [outstanding_depth];
  logic [ptr_w-1:0] wr_ptr, rd_ptr;
  logic [ptr_w:0]   count;

  // Register update delay applies to simulation only and has no synthesizable meaning.
  logic sim_delay_unused;
  assign sim_delay_unused = (simulation_delay != 0);

  assign fifo_full  = (count == depth_cnt);
  assign fifo_empty = (count == '0);
  assign head_id    = id_mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      grant_id <= 1'b0;
      last_id  <= 1'b1;
    end else begin
      state    <= state_nxt;
      grant_id <= grant_nxt;
      last_id  <= last_nxt;
    end
  end

  always_comb begin
    state_nxt        = state;
    grant_nxt        = grant_id;
    last_nxt         = last_id;
    push             = 1'b0;
    m_icb_cmd_addr   = '0;
    m_icb_cmd_read   = 1'b0;
    m_icb_cmd_wdata  = '0;
    m_icb_cmd_wmask  = '0;
    m_icb_cmd_valid  = 1'b0;
    s0_icb_cmd_ready = 1'b0;
    s1_icb_cmd_ready = 1'b0;
    case (state)
      IDLE: begin
        if ((s0_icb_cmd_valid || s1_icb_cmd_valid) && !fifo_full) begin
          // On a tie the master that did not win last time gets the grant.
          grant_nxt = (s0_icb_cmd_valid && s1_icb_cmd_valid) ? ~last_id : s1_icb_cmd_valid;
          state_nxt = BUSY;
        end
      end
      BUSY: begin
        m_icb_cmd_addr  = grant_id ? s1_icb_cmd_addr  : s0_icb_cmd_addr;
        m_icb_cmd_read  = grant_id ? s1_icb_cmd_read  : s0_icb_cmd_read;
        m_icb_cmd_wdata = grant_id ? s1_icb_cmd_wdata : s0_icb_cmd_wdata;
        m_icb_cmd_wmask = grant_id ? s1_icb_cmd_wmask : s0_icb_cmd_wmask;
        m_icb_cmd_valid = (grant_id ? s1_icb_cmd_valid : s0_icb_cmd_valid) & ~fifo_full & ~rst;
        if (grant_id) s1_icb_cmd_ready = m_icb_cmd_ready & ~fifo_full & ~rst;
        else          s0_icb_cmd_ready = m_icb_cmd_ready & ~fifo_full & ~rst;
        if (m_icb_cmd_valid && m_icb_cmd_ready) begin
          push      = 1'b1;
          last_nxt  = grant_id;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    s0_icb_rsp_valid = m_icb_rsp_valid & ~fifo_empty & ~head_id & ~rst;
    s1_icb_rsp_valid = m_icb_rsp_valid & ~fifo_empty &  head_id & ~rst;
    s0_icb_rsp_rdata = (!fifo_empty && !head_id) ? m_icb_rsp_rdata : '0;
    s0_icb_rsp_err   = (!fifo_empty && !head_id) ? m_icb_rsp_err   : 1'b0;
    s1_icb_rsp_rdata = (!fifo_empty &&  head_id) ? m_icb_rsp_rdata : '0;
    s1_icb_rsp_err   = (!fifo_empty &&  head_id) ? m_icb_rsp_err   : 1'b0;
    m_icb_rsp_ready  = ~fifo_empty & ~rst & (head_id ? s1_icb_rsp_ready : s0_icb_rsp_ready);
    pop              = m_icb_rsp_valid & m_icb_rsp_ready;
  end

  always_ff @(posedge clk) begin
    if (push) id_mem[wr_ptr] <= grant_id;
  end

  // Depth is a power of two, so pointers wrap by natural overflow.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_icb_2m_to_1s_arb.sv
// Bench for icb_2m_to_1s_arb: directed scenarios plus a randomized run checked
// against a transaction-level model (owner-ID queue, grant and last winner).
module tb_icb_2m_to_1s_arb;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] s0_icb_cmd_addr, s1_icb_cmd_addr;
  logic        s0_icb_cmd_read, s1_icb_cmd_read;
  logic [31:0] s0_icb_cmd_wdata, s1_icb_cmd_wdata;
  logic [3:0]  s0_icb_cmd_wmask, s1_icb_cmd_wmask;
  logic        s0_icb_cmd_valid, s1_icb_cmd_valid;
  logic        s0_icb_cmd_ready, s1_icb_cmd_ready;
  logic [31:0] s0_icb_rsp_rdata, s1_icb_rsp_rdata;
  logic        s0_icb_rsp_err, s1_icb_rsp_err;
  logic        s0_icb_rsp_valid, s1_icb_rsp_valid;
  logic        s0_icb_rsp_ready, s1_icb_rsp_ready;
  logic [31:0] m_icb_cmd_addr;
  logic        m_icb_cmd_read;
  logic [31:0] m_icb_cmd_wdata;
  logic [3:0]  m_icb_cmd_wmask;
  logic        m_icb_cmd_valid, m_icb_cmd_ready;
  logic [31:0] m_icb_rsp_rdata;
  logic        m_icb_rsp_err, m_icb_rsp_valid, m_icb_rsp_ready;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  bit mdl_busy;
  int mdl_gnt;
  int mdl_last;
  int mdl_ids[$];

  icb_2m_to_1s_arb #(.outstanding_depth(DEPTH), .simulation_delay(1)) dut (
    .clk(clk), .rst(rst),
    .s0_icb_cmd_addr(s0_icb_cmd_addr), .s0_icb_cmd_read(s0_icb_cmd_read),
    .s0_icb_cmd_wdata(s0_icb_cmd_wdata), .s0_icb_cmd_wmask(s0_icb_cmd_wmask),
    .s0_icb_cmd_valid(s0_icb_cmd_valid), .s0_icb_cmd_ready(s0_icb_cmd_ready),
    .s0_icb_rsp_rdata(s0_icb_rsp_rdata), .s0_icb_rsp_err(s0_icb_rsp_err),
    .s0_icb_rsp_valid(s0_icb_rsp_valid), .s0_icb_rsp_ready(s0_icb_rsp_ready),
    .s1_icb_cmd_addr(s1_icb_cmd_addr), .s1_icb_cmd_read(s1_icb_cmd_read),
    .s1_icb_cmd_wdata(s1_icb_cmd_wdata), .s1_icb_cmd_wmask(s1_icb_cmd_wmask),
    .s1_icb_cmd_valid(s1_icb_cmd_valid), .s1_icb_cmd_ready(s1_icb_cmd_ready),
    .s1_icb_rsp_rdata(s1_icb_rsp_rdata), .s1_icb_rsp_err(s1_icb_rsp_err),
    .s1_icb_rsp_valid(s1_icb_rsp_valid), .s1_icb_rsp_ready(s1_icb_rsp_ready),
    .m_icb_cmd_addr(m_icb_cmd_addr), .m_icb_cmd_read(m_icb_cmd_read),
    .m_icb_cmd_wdata(m_icb_cmd_wdata), .m_icb_cmd_wmask(m_icb_cmd_wmask),
    .m_icb_cmd_valid(m_icb_cmd_valid), .m_icb_cmd_ready(m_icb_cmd_ready),
    .m_icb_rsp_rdata(m_icb_rsp_rdata), .m_icb_rsp_err(m_icb_rsp_err),
    .m_icb_rsp_valid(m_icb_rsp_valid), .m_icb_rsp_ready(m_icb_rsp_ready)
  );

  always #5 clk = ~clk;

  function automatic logic [5:0] hs_vec();
    return {m_icb_cmd_valid, s0_icb_cmd_ready, s1_icb_cmd_ready,
            s0_icb_rsp_valid, s1_icb_rsp_valid, m_icb_rsp_ready};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    s0_icb_cmd_addr = '0; s0_icb_cmd_read = 1'b0; s0_icb_cmd_wdata = '0; s0_icb_cmd_wmask = '0;
    s1_icb_cmd_addr = '0; s1_icb_cmd_read = 1'b0; s1_icb_cmd_wdata = '0; s1_icb_cmd_wmask = '0;
    s0_icb_cmd_valid = 1'b0; s1_icb_cmd_valid = 1'b0;
    s0_icb_rsp_ready = 1'b0; s1_icb_rsp_ready = 1'b0;
    m_icb_cmd_ready = 1'b0; m_icb_rsp_valid = 1'b0;
    m_icb_rsp_rdata = '0; m_icb_rsp_err = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    mdl_busy = 1'b0;
    mdl_gnt  = 0;
    mdl_last = 1;
    mdl_ids.delete();
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    s0_icb_cmd_valid = 1'b1; s1_icb_cmd_valid = 1'b1;
    s0_icb_cmd_addr = 32'h100; s1_icb_cmd_addr = 32'h200;
    m_icb_cmd_ready = 1'b1; m_icb_rsp_valid = 1'b1;
    s0_icb_rsp_ready = 1'b1; s1_icb_rsp_ready = 1'b1;
    tick();
    @(negedge clk);
    n_checks++;
    if (hs_vec() !== 6'b0) begin
      n_fail++; $display("FAIL reset_hold: handshakes=%b expected %b", hs_vec(), 6'b0);
    end
    tick();
    rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if (hs_vec() !== 6'b0) begin
      n_fail++; $display("FAIL reset_after: handshakes=%b expected %b", hs_vec(), 6'b0);
    end
    tick();
    @(negedge clk);
    n_checks++;
    if ({hs_vec(), m_icb_cmd_addr} !== {6'b110000, 32'h100}) begin
      n_fail++; $display("FAIL reset_first_tie: hs=%b addr=%h expected hs=110000 addr=00000100",
                         hs_vec(), m_icb_cmd_addr);
    end
    do_reset();
  endtask

  task automatic test_single();
    do_reset();
    m_icb_cmd_ready = 1'b1;
    s0_icb_cmd_valid = 1'b1; s0_icb_cmd_addr = 32'h1000_0004; s0_icb_cmd_read = 1'b1;
    s0_icb_cmd_wmask = 4'hf;
    @(negedge clk);
    n_checks++;
    if (m_icb_cmd_valid !== 1'b0) begin
      n_fail++; $display("FAIL single_idle: m_valid=%b expected 0", m_icb_cmd_valid);
    end
    tick();
    @(negedge clk);
    n_checks++;
    if ({m_icb_cmd_valid, m_icb_cmd_addr, m_icb_cmd_read, s0_icb_cmd_ready, s1_icb_cmd_ready}
        !== {1'b1, 32'h1000_0004, 1'b1, 1'b1, 1'b0}) begin
      n_fail++; $display("FAIL single_cmd: valid=%b addr=%h read=%b r0=%b r1=%b expected 1 10000004 1 1 0",
                         m_icb_cmd_valid, m_icb_cmd_addr, m_icb_cmd_read, s0_icb_cmd_ready, s1_icb_cmd_ready);
    end
    tick();
    s0_icb_cmd_valid = 1'b0;
    m_icb_rsp_valid = 1'b1; m_icb_rsp_rdata = 32'hDEAD_BEEF; s0_icb_rsp_ready = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({s0_icb_rsp_valid, s0_icb_rsp_rdata, s1_icb_rsp_valid, m_icb_rsp_ready}
        !== {1'b1, 32'hDEAD_BEEF, 1'b0, 1'b1}) begin
      n_fail++; $display("FAIL single_rsp: v0=%b d0=%h v1=%b mrr=%b expected 1 deadbeef 0 1",
                         s0_icb_rsp_valid, s0_icb_rsp_rdata, s1_icb_rsp_valid, m_icb_rsp_ready);
    end
    tick();
    @(negedge clk);
    n_checks++;
    if ({s0_icb_rsp_valid, s1_icb_rsp_valid, m_icb_rsp_ready} !== 3'b000) begin
      n_fail++; $display("FAIL stray_rsp: v0=%b v1=%b mrr=%b expected 000",
                         s0_icb_rsp_valid, s1_icb_rsp_valid, m_icb_rsp_ready);
    end
    tick();
  endtask

  task automatic test_round_robin();
    logic [31:0] got[$];
    logic [31:0] exp_addr[4];
    int          exp_id[4];
    int          cycles;
    exp_addr = '{32'h100, 32'h200, 32'h100, 32'h200};
    exp_id   = '{0, 1, 0, 1};
    do_reset();
    m_icb_cmd_ready = 1'b1;
    s0_icb_cmd_valid = 1'b1; s0_icb_cmd_addr = 32'h100; s0_icb_cmd_read = 1'b1;
    s1_icb_cmd_valid = 1'b1; s1_icb_cmd_addr = 32'h200; s1_icb_cmd_read = 1'b1;
    cycles = 0;
    while (cycles < 20 && got.size() < 4) begin
      @(negedge clk);
      if (m_icb_cmd_valid && m_icb_cmd_ready) got.push_back(m_icb_cmd_addr);
      tick();
      cycles++;
      if (got.size() == 4) begin
        s0_icb_cmd_valid = 1'b0; s1_icb_cmd_valid = 1'b0;
      end
    end
    n_checks++;
    if (got.size() != 4 || cycles != 8) begin
      n_fail++; $display("FAIL rr_count: accepted=%0d in %0d cycles expected 4 in 8", got.size(), cycles);
    end
    for (int i = 0; i < got.size() && i < 4; i++) begin
      n_checks++;
      if (got[i] !== exp_addr[i]) begin
        n_fail++; $display("FAIL rr_order[%0d]: addr=%h expected %h", i, got[i], exp_addr[i]);
      end
    end
    m_icb_rsp_valid = 1'b1; s0_icb_rsp_ready = 1'b1; s1_icb_rsp_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      m_icb_rsp_rdata = 32'hA000_0000 + 32'(i);
      @(negedge clk);
      n_checks++;
      if ({s0_icb_rsp_valid, s1_icb_rsp_valid} !== ((exp_id[i] == 1) ? 2'b01 : 2'b10)) begin
        n_fail++; $display("FAIL rr_rsp_owner[%0d]: v0=%b v1=%b expected owner %0d",
                           i, s0_icb_rsp_valid, s1_icb_rsp_valid, exp_id[i]);
      end
      tick();
    end
    @(negedge clk);
    n_checks++;
    if (m_icb_rsp_ready !== 1'b0) begin
      n_fail++; $display("FAIL rr_drained: mrr=%b expected 0", m_icb_rsp_ready);
    end
    tick();
    m_icb_rsp_valid = 1'b0;
  endtask

  task automatic test_outstanding();
    int hs;
    do_reset();
    m_icb_cmd_ready = 1'b1;
    s0_icb_cmd_valid = 1'b1; s0_icb_cmd_addr = 32'h2000; s0_icb_cmd_read = 1'b1;
    hs = 0;
    for (int c = 0; c < 14; c++) begin
      @(negedge clk);
      if (m_icb_cmd_valid && m_icb_cmd_ready) hs++;
      tick();
    end
    n_checks++;
    if (hs != DEPTH) begin
      n_fail++; $display("FAIL limit_count: accepted=%0d expected %0d", hs, DEPTH);
    end
    @(negedge clk);
    n_checks++;
    if ({m_icb_cmd_valid, s0_icb_cmd_ready} !== 2'b00) begin
      n_fail++; $display("FAIL limit_full: m_valid=%b r0=%b expected 00", m_icb_cmd_valid, s0_icb_cmd_ready);
    end
    tick();
    m_icb_rsp_valid = 1'b1; s0_icb_rsp_ready = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({m_icb_rsp_ready, m_icb_cmd_valid} !== 2'b10) begin
      n_fail++; $display("FAIL limit_pop: mrr=%b m_valid=%b expected 1 0", m_icb_rsp_ready, m_icb_cmd_valid);
    end
    tick();
    m_icb_rsp_valid = 1'b0;
    @(negedge clk);
    n_checks++;
    if (m_icb_cmd_valid !== 1'b0) begin
      n_fail++; $display("FAIL limit_regrant: m_valid=%b expected 0", m_icb_cmd_valid);
    end
    tick();
    @(negedge clk);
    n_checks++;
    if ({m_icb_cmd_valid, s0_icb_cmd_ready} !== 2'b11) begin
      n_fail++; $display("FAIL limit_fifth: m_valid=%b r0=%b expected 11", m_icb_cmd_valid, s0_icb_cmd_ready);
    end
    tick();
    s0_icb_cmd_valid = 1'b0;
  endtask

  task automatic test_backpressure();
    do_reset();
    s1_icb_cmd_valid = 1'b1; s1_icb_cmd_addr = 32'h300; s1_icb_cmd_read = 1'b0;
    s1_icb_cmd_wdata = 32'hCAFE_F00D; s1_icb_cmd_wmask = 4'h3;
    tick();
    for (int c = 0; c < 5; c++) begin
      if (c == 1) begin
        s0_icb_cmd_valid = 1'b1; s0_icb_cmd_addr = 32'h400; s0_icb_cmd_read = 1'b1;
      end
      @(negedge clk);
      n_checks++;
      if ({m_icb_cmd_valid, m_icb_cmd_addr, m_icb_cmd_read, m_icb_cmd_wdata, m_icb_cmd_wmask,
           s0_icb_cmd_ready, s1_icb_cmd_ready}
          !== {1'b1, 32'h300, 1'b0, 32'hCAFE_F00D, 4'h3, 1'b0, 1'b0}) begin
        n_fail++; $display("FAIL bp_hold[%0d]: v=%b addr=%h wdata=%h mask=%h r0=%b r1=%b expected 1 300 cafef00d 3 0 0",
                           c, m_icb_cmd_valid, m_icb_cmd_addr, m_icb_cmd_wdata, m_icb_cmd_wmask,
                           s0_icb_cmd_ready, s1_icb_cmd_ready);
      end
      tick();
    end
    m_icb_cmd_ready = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({m_icb_cmd_valid, m_icb_cmd_addr, s1_icb_cmd_ready, s0_icb_cmd_ready} !== {1'b1, 32'h300, 1'b1, 1'b0}) begin
      n_fail++; $display("FAIL bp_release: v=%b addr=%h r1=%b r0=%b expected 1 300 1 0",
                         m_icb_cmd_valid, m_icb_cmd_addr, s1_icb_cmd_ready, s0_icb_cmd_ready);
    end
    tick();
    s1_icb_cmd_valid = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({m_icb_cmd_valid, s0_icb_cmd_ready, s1_icb_cmd_ready} !== 3'b000) begin
      n_fail++; $display("FAIL bp_single_pulse: v=%b r0=%b r1=%b expected 000",
                         m_icb_cmd_valid, s0_icb_cmd_ready, s1_icb_cmd_ready);
    end
    tick();
    @(negedge clk);
    n_checks++;
    if ({m_icb_cmd_valid, m_icb_cmd_addr, s0_icb_cmd_ready, s1_icb_cmd_ready} !== {1'b1, 32'h400, 1'b1, 1'b0}) begin
      n_fail++; $display("FAIL bp_next_s0: v=%b addr=%h r0=%b r1=%b expected 1 400 1 0",
                         m_icb_cmd_valid, m_icb_cmd_addr, s0_icb_cmd_ready, s1_icb_cmd_ready);
    end
    tick();
    s0_icb_cmd_valid = 1'b0; m_icb_cmd_ready = 1'b0;
  endtask

  // Continues from test_backpressure: owners outstanding are 1 then 0.
  task automatic test_rsp_backpressure();
    m_icb_rsp_valid = 1'b1; m_icb_rsp_rdata = 32'h1111_2222; m_icb_rsp_err = 1'b0;
    s1_icb_rsp_ready = 1'b0; s0_icb_rsp_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      n_checks++;
      if ({s1_icb_rsp_valid, s0_icb_rsp_valid, m_icb_rsp_ready} !== 3'b100) begin
        n_fail++; $display("FAIL rsp_bp[%0d]: v1=%b v0=%b mrr=%b expected 100",
                           c, s1_icb_rsp_valid, s0_icb_rsp_valid, m_icb_rsp_ready);
      end
      tick();
    end
    s1_icb_rsp_ready = 1'b1; m_icb_rsp_err = 1'b1; m_icb_rsp_rdata = 32'h5555_AAAA;
    @(negedge clk);
    n_checks++;
    if ({s1_icb_rsp_valid, s1_icb_rsp_rdata, s1_icb_rsp_err, m_icb_rsp_ready,
         s0_icb_rsp_valid, s0_icb_rsp_rdata, s0_icb_rsp_err}
        !== {1'b1, 32'h5555_AAAA, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0}) begin
      n_fail++; $display("FAIL rsp_err_s1: v1=%b d1=%h e1=%b mrr=%b v0=%b d0=%h e0=%b expected 1 5555aaaa 1 1 0 0 0",
                         s1_icb_rsp_valid, s1_icb_rsp_rdata, s1_icb_rsp_err, m_icb_rsp_ready,
                         s0_icb_rsp_valid, s0_icb_rsp_rdata, s0_icb_rsp_err);
    end
    tick();
    m_icb_rsp_err = 1'b0; m_icb_rsp_rdata = 32'h7777_0000;
    @(negedge clk);
    n_checks++;
    if ({s0_icb_rsp_valid, s0_icb_rsp_rdata, s0_icb_rsp_err, s1_icb_rsp_valid, s1_icb_rsp_rdata, s1_icb_rsp_err}
        !== {1'b1, 32'h7777_0000, 1'b0, 1'b0, 32'h0, 1'b0}) begin
      n_fail++; $display("FAIL rsp_next_s0: v0=%b d0=%h e0=%b v1=%b d1=%h e1=%b expected 1 77770000 0 0 0 0",
                         s0_icb_rsp_valid, s0_icb_rsp_rdata, s0_icb_rsp_err,
                         s1_icb_rsp_valid, s1_icb_rsp_rdata, s1_icb_rsp_err);
    end
    tick();
    m_icb_rsp_valid = 1'b0;
  endtask

  task automatic test_reset_mid();
    int hs;
    do_reset();
    m_icb_cmd_ready = 1'b1;
    s0_icb_cmd_valid = 1'b1; s0_icb_cmd_addr = 32'h3000;
    hs = 0;
    for (int c = 0; c < 12 && hs < 3; c++) begin
      @(negedge clk);
      if (m_icb_cmd_valid && m_icb_cmd_ready) hs++;
      tick();
    end
    s0_icb_cmd_valid = 1'b0;
    n_checks++;
    if (hs != 3) begin
      n_fail++; $display("FAIL midrst_setup: accepted=%0d expected 3", hs);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    m_icb_rsp_valid = 1'b1; s0_icb_rsp_ready = 1'b1; s1_icb_rsp_ready = 1'b1;
    @(negedge clk);
    n_checks++;
    if (hs_vec() !== 6'b0) begin
      n_fail++; $display("FAIL midrst_cleared: hs=%b expected 000000", hs_vec());
    end
    tick();
    m_icb_rsp_valid = 1'b0;
    s0_icb_cmd_valid = 1'b1; s0_icb_cmd_addr = 32'h100;
    s1_icb_cmd_valid = 1'b1; s1_icb_cmd_addr = 32'h200;
    tick();
    @(negedge clk);
    n_checks++;
    if ({m_icb_cmd_valid, m_icb_cmd_addr, s0_icb_cmd_ready, s1_icb_cmd_ready} !== {1'b1, 32'h100, 1'b1, 1'b0}) begin
      n_fail++; $display("FAIL midrst_tie: v=%b addr=%h r0=%b r1=%b expected 1 100 1 0",
                         m_icb_cmd_valid, m_icb_cmd_addr, s0_icb_cmd_ready, s1_icb_cmd_ready);
    end
    tick();
    idle_inputs();
  endtask

  task automatic test_random();
    bit          acc0, acc1, full, e_pop;
    bit          e_mv, e_r0, e_r1, e_rv0, e_rv1, e_mrr;
    logic [68:0] e_cmd;
    logic [65:0] e_rsp;
    int          head;
    do_reset();
    acc0 = 1'b0; acc1 = 1'b0;
    for (int c = 0; c < 800; c++) begin
      if (!s0_icb_cmd_valid || acc0) begin
        s0_icb_cmd_valid = ($urandom_range(0, 99) < 60);
        s0_icb_cmd_addr  = $urandom; s0_icb_cmd_read = 1'($urandom_range(0, 1));
        s0_icb_cmd_wdata = $urandom; s0_icb_cmd_wmask = 4'($urandom_range(0, 15));
      end
      if (!s1_icb_cmd_valid || acc1) begin
        s1_icb_cmd_valid = ($urandom_range(0, 99) < 60);
        s1_icb_cmd_addr  = $urandom; s1_icb_cmd_read = 1'($urandom_range(0, 1));
        s1_icb_cmd_wdata = $urandom; s1_icb_cmd_wmask = 4'($urandom_range(0, 15));
      end
      m_icb_cmd_ready  = ($urandom_range(0, 3) != 0);
      m_icb_rsp_valid  = 1'($urandom_range(0, 1));
      m_icb_rsp_rdata  = $urandom;
      m_icb_rsp_err    = 1'($urandom_range(0, 1));
      s0_icb_rsp_ready = 1'($urandom_range(0, 1));
      s1_icb_rsp_ready = 1'($urandom_range(0, 1));
      @(negedge clk);

      full = (mdl_ids.size() == DEPTH);
      e_mv = 1'b0; e_r0 = 1'b0; e_r1 = 1'b0; e_cmd = '0;
      if (mdl_busy) begin
        e_mv  = ((mdl_gnt == 1) ? s1_icb_cmd_valid : s0_icb_cmd_valid) && !full;
        e_r0  = (mdl_gnt == 0) && m_icb_cmd_ready && !full;
        e_r1  = (mdl_gnt == 1) && m_icb_cmd_ready && !full;
        e_cmd = (mdl_gnt == 1) ? {s1_icb_cmd_addr, s1_icb_cmd_read, s1_icb_cmd_wdata, s1_icb_cmd_wmask}
                               : {s0_icb_cmd_addr, s0_icb_cmd_read, s0_icb_cmd_wdata, s0_icb_cmd_wmask};
      end
      e_rv0 = 1'b0; e_rv1 = 1'b0; e_mrr = 1'b0; e_rsp = '0;
      if (mdl_ids.size() > 0) begin
        head = mdl_ids[0];
        if (head == 0) begin
          e_rv0 = m_icb_rsp_valid; e_mrr = s0_icb_rsp_ready;
          e_rsp = {m_icb_rsp_rdata, m_icb_rsp_err, 33'h0};
        end else begin
          e_rv1 = m_icb_rsp_valid; e_mrr = s1_icb_rsp_ready;
          e_rsp = {33'h0, m_icb_rsp_rdata, m_icb_rsp_err};
        end
      end

      n_checks++;
      if (hs_vec() !== {e_mv, e_r0, e_r1, e_rv0, e_rv1, e_mrr}) begin
        n_fail++; $display("FAIL rand_hs cycle %0d: hs=%b expected %b", c, hs_vec(),
                           {e_mv, e_r0, e_r1, e_rv0, e_rv1, e_mrr});
      end
      if (mdl_busy) begin
        n_checks++;
        if ({m_icb_cmd_addr, m_icb_cmd_read, m_icb_cmd_wdata, m_icb_cmd_wmask} !== e_cmd) begin
          n_fail++; $display("FAIL rand_cmd cycle %0d: cmd=%h expected %h", c,
                             {m_icb_cmd_addr, m_icb_cmd_read, m_icb_cmd_wdata, m_icb_cmd_wmask}, e_cmd);
        end
      end
      n_checks++;
      if ({s0_icb_rsp_rdata, s0_icb_rsp_err, s1_icb_rsp_rdata, s1_icb_rsp_err} !== e_rsp) begin
        n_fail++; $display("FAIL rand_rsp cycle %0d: rsp=%h expected %h", c,
                           {s0_icb_rsp_rdata, s0_icb_rsp_err, s1_icb_rsp_rdata, s1_icb_rsp_err}, e_rsp);
      end

      acc0  = s0_icb_cmd_valid && e_r0;
      acc1  = s1_icb_cmd_valid && e_r1;
      e_pop = m_icb_rsp_valid && e_mrr;
      @(posedge clk);
      if (e_pop) void'(mdl_ids.pop_front());
      if (mdl_busy) begin
        if (e_mv && m_icb_cmd_ready) begin
          mdl_ids.push_back(mdl_gnt);
          mdl_last = mdl_gnt;
          mdl_busy = 1'b0;
        end
      end else if ((s0_icb_cmd_valid || s1_icb_cmd_valid) && !full) begin
        mdl_gnt  = (s0_icb_cmd_valid && s1_icb_cmd_valid) ? (1 - mdl_last) : (s1_icb_cmd_valid ? 1 : 0);
        mdl_busy = 1'b1;
      end
      #1;
    end
    idle_inputs();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    idle_inputs();
    rst = 1'b1;
    #1;
    test_reset();
    test_single();
    test_round_robin();
    test_outstanding();
    test_backpressure();
    test_rsp_backpressure();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
